// File: rtl/dbg_bus_master_if.sv
// Byte-stream and native memory bus signals of the debug initiator.
// The master modport is the dbg_bus_master side; slave is the UART/SoC side.
interface dbg_bus_master_if;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_ready;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;

   modport master (
      input  in_valid, in_data, out_ready, mem_ready, mem_rdata,
      output out_valid, out_data, mem_valid, mem_addr, mem_wdata, mem_wstrb
   );

   modport slave (
      output in_valid, in_data, out_ready, mem_ready, mem_rdata,
      input  out_valid, out_data, mem_valid, mem_addr, mem_wdata, mem_wstrb
   );
endinterface

// File: rtl/dbg_bus_master.sv
// Serial-command debug initiator: byte frames in, one 32-bit bus access per
// frame, response bytes out. A single transaction is ever outstanding.
module dbg_bus_master #(
   parameter int BUS_TIMEOUT   = 1024,
   parameter int FRAME_TIMEOUT = 100000
) (
   input  logic                    clk,
   input  logic                    rst,
   dbg_bus_master_if.master        bus,
   output logic                    busy,
   output logic [2:0]              o_dbg_state
);

   // Handshakes: in_valid is a one-cycle strobe with no back-pressure;
   // out_data transfers on a cycle where out_valid && out_ready; a bus
   // request completes on the first edge that sees mem_valid && mem_ready.

   localparam int FW = $clog2(FRAME_TIMEOUT + 1);
   localparam int BW = $clog2(BUS_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ADDR = 3'd1,
      S_DATA = 3'd2,
      S_BUS  = 3'd3,
      S_RESP = 3'd4
   } state_e;

   state_e        r_state,     w_state_n;
   logic          r_write,     w_write_n;
   logic          r_nak,       w_nak_n;
   logic [2:0]    r_idx,       w_idx_n;
   logic [FW-1:0] r_frame_cnt, w_frame_cnt_n;
   logic [BW-1:0] r_bus_cnt,   w_bus_cnt_n;
   logic [31:0]   r_addr,      w_addr_n;
   logic [31:0]   r_wdata,     w_wdata_n;
   logic [3:0]    r_wstrb,     w_wstrb_n;
   logic          r_mem_valid, w_mem_valid_n;
   logic [31:0]   r_rdata,     w_rdata_n;
   logic [7:0]    r_status,    w_status_n;
   logic          r_out_valid, w_out_valid_n;
   logic [7:0]    r_out_data,  w_out_data_n;

   logic [7:0]    w_resp_byte;
   logic          w_resp_last;
   logic          w_cmd_bad;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_write     <= 1'b0;
         r_nak       <= 1'b0;
         r_idx       <= 3'd0;
         r_frame_cnt <= '0;
         r_bus_cnt   <= '0;
         r_addr      <= 32'd0;
         r_wdata     <= 32'd0;
         r_wstrb     <= 4'd0;
         r_mem_valid <= 1'b0;
         r_rdata     <= 32'd0;
         r_status    <= 8'd0;
         r_out_valid <= 1'b0;
         r_out_data  <= 8'd0;
      end else begin
         r_state     <= w_state_n;
         r_write     <= w_write_n;
         r_nak       <= w_nak_n;
         r_idx       <= w_idx_n;
         r_frame_cnt <= w_frame_cnt_n;
         r_bus_cnt   <= w_bus_cnt_n;
         r_addr      <= w_addr_n;
         r_wdata     <= w_wdata_n;
         r_wstrb     <= w_wstrb_n;
         r_mem_valid <= w_mem_valid_n;
         r_rdata     <= w_rdata_n;
         r_status    <= w_status_n;
         r_out_valid <= w_out_valid_n;
         r_out_data  <= w_out_data_n;
      end
   end

   // Response byte for the current index: NAK, status-only, or 4 data + status.
   always_comb begin
      w_resp_byte = r_status;
      w_resp_last = 1'b1;
      if (r_nak) begin
         w_resp_byte = 8'h15;
      end else if (!r_write) begin
         w_resp_last = (r_idx == 3'd4);
         case (r_idx)
            3'd0:    w_resp_byte = r_rdata[7:0];
            3'd1:    w_resp_byte = r_rdata[15:8];
            3'd2:    w_resp_byte = r_rdata[23:16];
            3'd3:    w_resp_byte = r_rdata[31:24];
            default: w_resp_byte = r_status;
         endcase
      end
   end

   assign w_cmd_bad = (bus.in_data[6:4] != 3'b000) ||
                      (bus.in_data[7] && (bus.in_data[3:0] == 4'b0000));

   always_comb begin
      w_state_n     = r_state;
      w_write_n     = r_write;
      w_nak_n       = r_nak;
      w_idx_n       = r_idx;
      w_frame_cnt_n = r_frame_cnt;
      w_bus_cnt_n   = r_bus_cnt;
      w_addr_n      = r_addr;
      w_wdata_n     = r_wdata;
      w_wstrb_n     = r_wstrb;
      w_mem_valid_n = r_mem_valid;
      w_rdata_n     = r_rdata;
      w_status_n    = r_status;
      w_out_valid_n = r_out_valid;
      w_out_data_n  = r_out_data;

      case (r_state)
         S_IDLE: begin
            if (bus.in_valid) begin
               w_idx_n       = 3'd0;
               w_frame_cnt_n = '0;
               w_write_n     = bus.in_data[7];
               if (w_cmd_bad) begin
                  w_nak_n   = 1'b1;
                  w_state_n = S_RESP;
               end else begin
                  w_nak_n   = 1'b0;
                  w_wstrb_n = bus.in_data[7] ? bus.in_data[3:0] : 4'b0000;
                  w_state_n = S_ADDR;
               end
            end
         end

         S_ADDR: begin
            if (bus.in_valid) begin
               w_frame_cnt_n = '0;
               w_addr_n[8*r_idx[1:0] +: 8] = bus.in_data;
               if (r_idx == 3'd3) begin
                  w_addr_n[1:0] = 2'b00;
                  w_idx_n       = 3'd0;
                  if (r_write) begin
                     w_state_n = S_DATA;
                  end else begin
                     w_state_n     = S_BUS;
                     w_mem_valid_n = 1'b1;
                     w_bus_cnt_n   = '0;
                  end
               end else begin
                  w_idx_n = r_idx + 3'd1;
               end
            end else if (r_frame_cnt == FW'(FRAME_TIMEOUT - 1)) begin
               w_state_n = S_IDLE;
            end else begin
               w_frame_cnt_n = r_frame_cnt + FW'(1);
            end
         end

         S_DATA: begin
            if (bus.in_valid) begin
               w_frame_cnt_n = '0;
               w_wdata_n[8*r_idx[1:0] +: 8] = bus.in_data;
               if (r_idx == 3'd3) begin
                  w_idx_n       = 3'd0;
                  w_state_n     = S_BUS;
                  w_mem_valid_n = 1'b1;
                  w_bus_cnt_n   = '0;
               end else begin
                  w_idx_n = r_idx + 3'd1;
               end
            end else if (r_frame_cnt == FW'(FRAME_TIMEOUT - 1)) begin
               w_state_n = S_IDLE;
            end else begin
               w_frame_cnt_n = r_frame_cnt + FW'(1);
            end
         end

         S_BUS: begin
            if (r_mem_valid && bus.mem_ready) begin
               w_mem_valid_n = 1'b0;
               w_status_n    = 8'h00;
               if (!r_write) w_rdata_n = bus.mem_rdata;
               w_idx_n       = 3'd0;
               w_state_n     = S_RESP;
            end else if (r_bus_cnt == BW'(BUS_TIMEOUT - 1)) begin
               // Abandoned access: report EE and never return stale read data.
               w_mem_valid_n = 1'b0;
               w_status_n    = 8'hEE;
               w_rdata_n     = 32'd0;
               w_idx_n       = 3'd0;
               w_state_n     = S_RESP;
            end else begin
               w_bus_cnt_n = r_bus_cnt + BW'(1);
            end
         end

         S_RESP: begin
            if (!r_out_valid) begin
               w_out_valid_n = 1'b1;
               w_out_data_n  = w_resp_byte;
            end else if (bus.out_ready) begin
               w_out_valid_n = 1'b0;
               if (w_resp_last) w_state_n = S_IDLE;
               else             w_idx_n   = r_idx + 3'd1;
            end
         end

         default: begin
            w_state_n     = S_IDLE;
            w_mem_valid_n = 1'b0;
            w_out_valid_n = 1'b0;
         end
      endcase
   end

   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.mem_valid = r_mem_valid;
   assign bus.mem_addr  = r_addr;
   assign bus.mem_wdata = r_wdata;
   assign bus.mem_wstrb = r_wstrb;
   assign busy          = (r_state != S_IDLE);
   assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_dbg_bus_master.sv
// Bench for dbg_bus_master: directed and random command frames, a memory
// responder, and a frame-level reference model of the expected bus traffic.
module tb_dbg_bus_master;
   localparam int BUS_TO   = 16;
   localparam int FRAME_TO = 200;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } req_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       busy;
   logic [2:0] dbg_state;

   dbg_bus_master_if bus ();

   dbg_bus_master #(.BUS_TIMEOUT(BUS_TO), .FRAME_TIMEOUT(FRAME_TO)) dut (
      .clk(clk), .rst(rst), .bus(bus), .busy(busy), .o_dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   logic [7:0]  exp_q[$];
   logic [7:0]  got_q[$];
   req_t        exp_req_q[$];
   req_t        req_q[$];
   int          len_q[$];
   logic [31:0] resp_mem[logic [31:0]];
   logic [31:0] ref_mem[logic [31:0]];
   int          n_checks = 0;
   int          n_errors = 0;
   bit          resp_en = 1'b1;
   int          resp_wait = 0;
   int          hold_low = 0;
   int          stab_viol = 0;
   int          bp_viol = 0;

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = old_v;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Memory responder: waits resp_wait cycles, then pulses mem_ready once.
   initial begin
      int wcnt;
      logic [31:0] a;
      wcnt = 0;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 32'd0;
      forever begin
         @(negedge clk);
         bus.mem_ready = 1'b0;
         bus.mem_rdata = $urandom;
         if (resp_en && bus.mem_valid === 1'b1 && rst === 1'b0) begin
            if (wcnt >= resp_wait) begin
               bus.mem_ready = 1'b1;
               a = bus.mem_addr;
               if (bus.mem_wstrb == 4'd0)
                  bus.mem_rdata = resp_mem.exists(a) ? resp_mem[a] : dflt(a);
               else
                  resp_mem[a] = merge(resp_mem.exists(a) ? resp_mem[a] : dflt(a),
                                      bus.mem_wdata, bus.mem_wstrb);
               wcnt = 0;
            end else begin
               wcnt++;
            end
         end else begin
            wcnt = 0;
            if (bus.mem_valid !== 1'b1 && $urandom_range(0, 7) == 0) bus.mem_ready = 1'b1;
         end
      end
   end

   // Bus monitor: records each request, its high duration and request stability.
   initial begin
      int run;
      req_t r;
      run = 0;
      forever begin
         @(negedge clk);
         if (bus.mem_valid === 1'b1) begin
            if (run == 0) begin
               r.addr = bus.mem_addr; r.wdata = bus.mem_wdata; r.wstrb = bus.mem_wstrb;
               req_q.push_back(r);
            end else if (bus.mem_addr !== r.addr || bus.mem_wdata !== r.wdata ||
                         bus.mem_wstrb !== r.wstrb) begin
               stab_viol++;
            end
            run++;
         end else if (run > 0) begin
            len_q.push_back(run);
            run = 0;
         end
      end
   end

   // Response collector with random and forced back-pressure.
   initial begin
      bit bp_pend;
      logic [7:0] bp_data;
      bp_pend = 1'b0;
      bp_data = 8'd0;
      bus.out_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (bp_pend && !(bus.out_valid === 1'b1 && bus.out_data === bp_data)) bp_viol++;
         if (bus.out_valid === 1'b1 && hold_low > 0) begin
            bus.out_ready = 1'b0;
            hold_low--;
         end else begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
         end
         if (bus.out_valid === 1'b1 && bus.out_ready) got_q.push_back(bus.out_data);
         bp_pend = (bus.out_valid === 1'b1) && !bus.out_ready;
         bp_data = bus.out_data;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = $urandom;
      repeat ($urandom_range(0, 2)) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] cmd, input logic [31:0] addr,
                             input logic [31:0] data, input bit full);
      send_byte(cmd);
      if (full) begin
         for (int k = 0; k < 4; k++) send_byte(addr[8*k +: 8]);
         if (cmd[7]) for (int k = 0; k < 4; k++) send_byte(data[8*k +: 8]);
      end
   endtask

   // Frame-level model: expected requests and response bytes for one command.
   task automatic model_cmd(input logic [7:0] cmd, input logic [31:0] addr,
                            input logic [31:0] data, input bit bus_ok, output bit bad);
      logic [31:0] a, v;
      req_t r;
      bad = (cmd[6:4] != 3'b000) || (cmd[7] && cmd[3:0] == 4'd0);
      if (bad) begin
         exp_q.push_back(8'h15);
         return;
      end
      a = {addr[31:2], 2'b00};
      r.addr = a; r.wdata = data; r.wstrb = cmd[7] ? cmd[3:0] : 4'd0;
      exp_req_q.push_back(r);
      if (cmd[7]) begin
         if (bus_ok) ref_mem[a] = merge(ref_mem.exists(a) ? ref_mem[a] : dflt(a), data, cmd[3:0]);
      end else begin
         v = bus_ok ? (ref_mem.exists(a) ? ref_mem[a] : dflt(a)) : 32'd0;
         for (int k = 0; k < 4; k++) exp_q.push_back(v[8*k +: 8]);
      end
      exp_q.push_back(bus_ok ? 8'h00 : 8'hEE);
   endtask

   task automatic run_cmd(input string tag, input logic [7:0] cmd, input logic [31:0] addr,
                          input logic [31:0] data, input bit bus_ok, input int wcyc,
                          input bit stray);
      bit bad;
      int t;
      resp_en   = bus_ok;
      resp_wait = (wcyc < 0) ? $urandom_range(0, 4) : wcyc;
      model_cmd(cmd, addr, data, bus_ok, bad);
      send_frame(cmd, addr, data, !bad);
      if (stray) begin
         repeat (3) @(negedge clk);
         send_byte(8'h80);
      end
      t = 0;
      while (busy === 1'b1 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      chk({tag, " busy_done"}, 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      chk({tag, " out_valid_idle"}, 32'(bus.out_valid), 32'd0);
      chk({tag, " nbytes"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         if (i < got_q.size()) chk($sformatf("%s byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
      chk({tag, " nreq"}, 32'(req_q.size()), 32'(exp_req_q.size()));
      for (int i = 0; i < exp_req_q.size(); i++) begin
         if (i < req_q.size()) begin
            chk({tag, " addr"}, req_q[i].addr, exp_req_q[i].addr);
            chk({tag, " wstrb"}, 32'(req_q[i].wstrb), 32'(exp_req_q[i].wstrb));
            if (exp_req_q[i].wstrb != 4'd0) chk({tag, " wdata"}, req_q[i].wdata, exp_req_q[i].wdata);
         end
         if (i < len_q.size())
            chk({tag, " valid_len"}, 32'(len_q[i]), bus_ok ? 32'(resp_wait + 1) : 32'(BUS_TO));
         else
            chk({tag, " valid_len_missing"}, 32'(len_q.size()), 32'(exp_req_q.size()));
      end
      exp_q.delete(); got_q.delete(); exp_req_q.delete(); req_q.delete(); len_q.delete();
   endtask

   initial begin
      int t;
      logic [7:0] cmd;
      logic [31:0] addr;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'd0;
      rst = 1'b1;
      repeat (5) @(negedge clk);
      chk("rst out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst out_data", 32'(bus.out_data), 32'd0);
      chk("rst mem_valid", 32'(bus.mem_valid), 32'd0);
      chk("rst mem_addr", bus.mem_addr, 32'd0);
      chk("rst mem_wdata", bus.mem_wdata, 32'd0);
      chk("rst mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      got_q.delete(); req_q.delete(); len_q.delete();

      resp_mem[32'h10] = 32'hDEAD_BEEF;
      ref_mem[32'h10]  = 32'hDEAD_BEEF;
      run_cmd("read_deadbeef", 8'h00, 32'h0000_0010, 32'd0, 1'b1, 2, 1'b0);
      run_cmd("write_full", 8'h8F, 32'h0100_0004, 32'h1234_5678, 1'b1, 1, 1'b0);
      run_cmd("write_half", 8'h83, 32'h0100_0004, 32'hA5A5_9876, 1'b1, 0, 1'b0);
      run_cmd("read_back", 8'h00, 32'h0100_0004, 32'd0, 1'b1, 3, 1'b0);
      run_cmd("read_unaligned", 8'h00, 32'h0000_0013, 32'd0, 1'b1, 1, 1'b0);
      run_cmd("nak_bits", 8'h40, 32'd0, 32'd0, 1'b1, 0, 1'b0);
      run_cmd("nak_wstrb0", 8'h80, 32'd0, 32'd0, 1'b1, 0, 1'b0);
      run_cmd("bus_timeout", 8'h00, 32'h0000_0200, 32'd0, 1'b0, 0, 1'b1);

      // Partial frame abandoned by silence, then a full read with back-pressure.
      resp_en = 1'b1;
      send_byte(8'h00);
      send_byte(8'h10);
      repeat (FRAME_TO + 20) @(negedge clk);
      chk("frame_to busy", 32'(busy), 32'd0);
      chk("frame_to nreq", 32'(req_q.size()), 32'd0);
      chk("frame_to nbytes", 32'(got_q.size()), 32'd0);
      hold_low = 10;
      run_cmd("read_bp", 8'h00, 32'h0000_0020, 32'd0, 1'b1, 1, 1'b0);

      // Reset while a request is on the bus.
      resp_en = 1'b0;
      send_frame(8'h00, 32'h0000_0040, 32'd0, 1'b1);
      t = 0;
      while (bus.mem_valid !== 1'b1 && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("rst_mid mem_valid_seen", 32'(bus.mem_valid), 32'd1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid mem_valid", 32'(bus.mem_valid), 32'd0);
      chk("rst_mid out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_mid busy", 32'(busy), 32'd0);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      chk("rst_mid nbytes", 32'(got_q.size()), 32'd0);
      got_q.delete(); req_q.delete(); len_q.delete();
      run_cmd("after_rst", 8'h00, 32'h0000_0010, 32'd0, 1'b1, -1, 1'b0);

      for (int n = 0; n < 30; n++) begin
         case ($urandom_range(0, 9))
            0: begin
               cmd = 8'($urandom);
               if (cmd[6:4] == 3'b000) cmd[5] = 1'b1;
            end
            1, 2, 3, 4: cmd = {4'b1000, 4'($urandom_range(0, 15))};
            default: cmd = 8'h00;
         endcase
         addr = 32'h100 + 32'($urandom_range(0, 31));
         run_cmd($sformatf("rand%0d", n), cmd, addr, $urandom, 1'b1, -1, 1'b0);
      end

      chk("req_stability", 32'(stab_viol), 32'd0);
      chk("out_backpressure", 32'(bp_viol), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end
endmodule
